// File: rtl/serial_code_lock_ctrl.sv
// Serial code lock sequencer: streams a code word MSB-first through an
// overlapping pattern matcher, decides unlock/fail and enforces lockout.
module serial_code_lock_ctrl #(
  parameter int WIDTH = 16,
  parameter int PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PATTERN = 5'b01001,
  parameter int REQ_MATCHES = 2,
  parameter int MAX_FAIL = 3,
  parameter int LOCKOUT_CYCLES = 8,
  localparam int CW = $clog2(WIDTH+1),
  localparam int FW = $clog2(MAX_FAIL+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             unlock,
  output logic [CW-1:0]    match_cnt,
  output logic [FW-1:0]    fail_cnt,
  output logic             locked_out
);

  localparam int LW = $clog2(LOCKOUT_CYCLES+1);
  localparam logic [CW-1:0] HIT_MIN = CW'(PAT_LEN-1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);
  localparam logic [CW-1:0] SAT = CW'(WIDTH);
  localparam logic [CW-1:0] REQ = CW'(REQ_MATCHES);
  localparam logic [FW-1:0] FMAX = FW'(MAX_FAIL);
  localparam logic [LW-1:0] LCYC = LW'(LOCKOUT_CYCLES);
  localparam logic [LW-1:0] LONE = LW'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    REPORT,
    LOCKOUT
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   sreg;
  logic [PAT_LEN-2:0] hist;
  logic [CW-1:0]      bcnt;
  logic [LW-1:0]      lcnt;

  logic               sbit;
  logic [PAT_LEN-1:0] nwin;
  logic               hit;
  logic [CW-1:0]      mnxt;
  logic               pass;

  // Counter guard stops the zeroed history from faking leading-zero hits.
  always_comb begin
    sbit = sreg[WIDTH-1];
    nwin = {hist, sbit};
    hit  = (nwin == PATTERN) && (bcnt >= HIT_MIN);
    mnxt = match_cnt;
    if (hit && match_cnt != SAT)
      mnxt = match_cnt + 1'b1;
    pass = (mnxt >= REQ);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sreg       <= '0;
      hist       <= '0;
      bcnt       <= '0;
      lcnt       <= '0;
      match_cnt  <= '0;
      fail_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      unlock     <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sreg      <= data_in;
            hist      <= '0;
            bcnt      <= '0;
            match_cnt <= '0;
            unlock    <= 1'b0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          sreg      <= {sreg[WIDTH-2:0], 1'b0};
          hist      <= nwin[PAT_LEN-2:0];
          match_cnt <= mnxt;
          bcnt      <= bcnt + 1'b1;
          if (bcnt == LAST) begin
            busy   <= 1'b0;
            done   <= 1'b1;
            unlock <= pass;
            if (pass)
              fail_cnt <= '0;
            else
              fail_cnt <= fail_cnt + 1'b1;
            state <= REPORT;
          end
        end
        REPORT: begin
          if (fail_cnt == FMAX) begin
            locked_out <= 1'b1;
            lcnt       <= LCYC;
            state      <= LOCKOUT;
          end else begin
            state <= IDLE;
          end
        end
        LOCKOUT: begin
          if (lcnt == LONE) begin
            fail_cnt   <= '0;
            locked_out <= 1'b0;
            state      <= IDLE;
          end else begin
            lcnt <= lcnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_code_lock_ctrl.md
Name: serial_code_lock_ctrl

Overview:
- Sequencing controller for the serial pattern-detector lock path.
- Accepts a parallel code word on a start/busy/done handshake and streams it MSB-first through an internal overlapping sequence matcher.
- Counts pattern hits and decides unlock/fail.
- Enforces a lockout window after repeated failed attempts; sits between the keypad/host interface and the lock actuator.

Parameters:
- WIDTH, 16, code word length in bits (serial cycles per attempt).
- PAT_LEN, 5, detected pattern length in bits.
- PATTERN, 5'b01001, bit sequence to detect, MSB first in time.
- REQ_MATCHES, 2, minimum hit count per word for unlock.
- MAX_FAIL, 3, consecutive failed attempts that trigger lockout.
- LOCKOUT_CYCLES, 8, lockout duration in clk cycles.
- Derived (localparam): CW = $clog2(WIDTH+1), FW = $clog2(MAX_FAIL+1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  attempt request; sampled only in IDLE.
- data_in  in  WIDTH  code word; captured on the accepted start edge.
- busy  out  1  high while serial shifting is in progress.
- done  out  1  one-cycle pulse when the attempt result is valid.
- unlock  out  1  result of last completed attempt; held until next accepted start.
- match_cnt  out  CW  hit count of the current or last attempt.
- fail_cnt  out  FW  consecutive failed attempts.
- locked_out  out  1  high during lockout.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low. Reset forces state=IDLE, shift reg=0, window=0, bit counter=0, match_cnt=0, fail_cnt=0, busy=0, done=0, unlock=0, locked_out=0.
- Reset asserted mid-operation aborts the attempt; no done pulse, fail_cnt is not incremented (cleared).
- States are IDLE, SHIFT, REPORT, LOCKOUT. All outputs are registered (Moore).
- IDLE:
  - start=1 at edge k: capture data_in, clear window/match_cnt/bit counter, unlock<=0, go to SHIFT.
  - start while not in IDLE is ignored (no queuing).
- SHIFT (busy=1) runs exactly WIDTH cycles. Each edge:
  - bit = sreg[WIDTH-1]; sreg shifts left with 0 fill.
  - window <= {window[PAT_LEN-2:0], bit}.
  - Hit when {window[PAT_LEN-2:0], bit} == PATTERN and bit counter >= PAT_LEN-1. Overlapping hits count.
  - match_cnt saturates at WIDTH (unreachable for valid params).
  - After the WIDTH-th bit, go to REPORT.
- Timing: busy is high in cycles k+1 .. k+WIDTH; done is high in cycle k+WIDTH+1.
- REPORT (done=1, busy=0, one cycle). On entry:
  - unlock <= (final match_cnt >= REQ_MATCHES).
  - Success: fail_cnt<=0, go to IDLE.
  - Failure: fail_cnt+1; if it reaches MAX_FAIL go to LOCKOUT, else go to IDLE.
- LOCKOUT (locked_out=1):
  - Down-counter loaded with LOCKOUT_CYCLES; start is ignored.
  - After LOCKOUT_CYCLES cycles: fail_cnt<=0, locked_out<=0, go to IDLE.
- start held high continuously: a new attempt is accepted on the first IDLE edge after REPORT (i.e. back-to-back with one IDLE cycle).
- match_cnt and unlock remain stable in IDLE until the next accepted start.

Test Plan:
- Reset low 2 cycles, release, then start with data_in=16'hA4D3 (1010010011010011). Required: busy high 16 cycles; done pulse at start+17; match_cnt=3 (overlapping hits at bit indices 1, 4, 10); unlock=1; fail_cnt=0.
- data_in=16'h4800. Required: match_cnt=1, unlock=0, fail_cnt=1. Then 16'hFFFF: match_cnt=0, fail_cnt=2.
- Three consecutive failures (16'hFFFF ×3). Required: after the third done, locked_out=1 for exactly 8 cycles; start pulses during lockout produce no busy; afterwards fail_cnt=0 and a new start is accepted.
- Two failures, then 16'hA4D3. Required: unlock=1 and fail_cnt cleared to 0 (no lockout).
- Pulse reset low at the 7th SHIFT cycle. Required: all outputs 0 immediately (async), no done pulse; a subsequent 16'hA4D3 attempt yields match_cnt=3.
- Assert start again during SHIFT with a different data_in. Required: ignored; result reflects the original word.
